// File: rtl/mem_arbiter_mp_if.sv
// mem_arbiter_mp_if: requester channels and byte-serial RAM/IO bus of mem_arbiter_mp
interface mem_arbiter_mp_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32
);
    logic [7:0]               mem_din;
    logic [7:0]               mem_dout;
    logic [ADDR_W-1:0]        mem_a;
    logic                     mem_wr;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_wr;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*32-1:0]     req_wdata;
    logic [NUM_CH*2-1:0]      req_size;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        flush;
    logic [NUM_CH-1:0]        resp_valid;
    logic [31:0]              resp_data;
    modport slave (
        input  mem_din, req_valid, req_wr, req_addr, req_wdata, req_size, flush,
        output mem_dout, mem_a, mem_wr, req_ready, resp_valid, resp_data
    );
    modport master (
        output mem_din, req_valid, req_wr, req_addr, req_wdata, req_size, flush,
        input  mem_dout, mem_a, mem_wr, req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter_mp.sv
// mem_arbiter_mp: round-robin NUM_CH-channel arbiter onto a pipelined byte-serial RAM/IO bus
module mem_arbiter_mp #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32
) (
    input logic clk_in,
    input logic rst_in,
    input logic rdy_in,
    mem_arbiter_mp_if.slave bus
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, RD, RD_DRAIN, WR} state_t;
    state_t            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d, ch_q, ch_d, grant, cand;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d, data_q, data_d, resp_data_q, resp_data_d;
    logic [2:0]        n_q, n_d, issue_q, issue_d, capt_q, capt_d, eff;
    logic              cap_pend_q, cap_pend_d, paused_q, paused_d, found, issuing;
    logic [NUM_CH-1:0] resp_valid_q, resp_valid_d;
    int                idx;

    function automatic logic [2:0] size2n(input logic [1:0] s);
        return s == 2'd0 ? 3'd1 : s == 2'd1 ? 3'd2 : 3'd4;
    endfunction

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_W'(idx);
            if (!found && bus.req_valid[cand] && !bus.flush[cand] && rdy_in) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // A read issues one byte ahead of capture; after a pause it restarts from the first uncaptured byte.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ch_d          = ch_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        n_d           = n_q;
        issue_d       = issue_q;
        capt_d        = capt_q;
        data_d        = data_q;
        cap_pend_d    = 1'b0;
        paused_d      = !rdy_in;
        resp_valid_d  = rdy_in ? '0 : resp_valid_q;
        resp_data_d   = rdy_in ? '0 : resp_data_q;
        eff           = paused_q ? capt_q : issue_q;
        issuing       = (state_q == RD || state_q == RD_DRAIN) && eff < n_q;
        bus.req_ready = '0;
        bus.mem_wr    = 1'b0;
        bus.mem_a     = '0;
        bus.mem_dout  = '0;
        if (state_q == WR) begin
            bus.mem_wr   = rdy_in;
            bus.mem_a    = base_q + ADDR_W'(issue_q);
            bus.mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
        end else if (issuing) begin
            bus.mem_a = base_q + ADDR_W'(eff);
        end
        if (state_q == IDLE) begin
            if (found) begin
                bus.req_ready[grant] = 1'b1;
                ptr_d   = grant;
                ch_d    = grant;
                base_d  = bus.req_addr[grant*ADDR_W +: ADDR_W];
                wdata_d = bus.req_wdata[grant*32 +: 32];
                n_d     = size2n(bus.req_size[grant*2 +: 2]);
                issue_d = '0;
                capt_d  = '0;
                data_d  = '0;
                state_d = bus.req_wr[grant] ? WR : RD;
            end
        end else if (state_q == WR) begin
            if (rdy_in) begin
                issue_d = issue_q + 3'd1;
                if (issue_d == n_q) begin
                    state_d              = IDLE;
                    resp_valid_d[ch_q]   = 1'b1;
                end
            end
        end else if (bus.flush[ch_q]) begin
            state_d = IDLE;
        end else if (rdy_in) begin
            issue_d    = issuing ? eff + 3'd1 : eff;
            cap_pend_d = issuing;
            if (cap_pend_q) begin
                data_d[{capt_q[1:0], 3'b000} +: 8] = bus.mem_din;
                capt_d = capt_q + 3'd1;
            end
            if (cap_pend_q && capt_d == n_q) begin
                state_d            = IDLE;
                resp_valid_d[ch_q] = 1'b1;
                resp_data_d        = data_d;
            end else begin
                state_d = issue_d == n_q ? RD_DRAIN : RD;
            end
        end
    end

    assign bus.resp_valid = rdy_in ? resp_valid_q : '0;
    assign bus.resp_data  = resp_data_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            ptr_q        <= CH_W'(NUM_CH - 1);
            ch_q         <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            n_q          <= '0;
            issue_q      <= '0;
            capt_q       <= '0;
            data_q       <= '0;
            cap_pend_q   <= 1'b0;
            paused_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ch_q         <= ch_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            n_q          <= n_d;
            issue_q      <= issue_d;
            capt_q       <= capt_d;
            data_q       <= data_d;
            cap_pend_q   <= cap_pend_d;
            paused_q     <= paused_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter_mp.sv
// tb_mem_arbiter_mp: directed scenarios for mem_arbiter_mp with three channels and a registered RAM model
module tb_mem_arbiter_mp;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] ram [logic [31:0]];

    mem_arbiter_mp_if #(.NUM_CH(3), .ADDR_W(32)) bus ();
    mem_arbiter_mp #(.NUM_CH(3), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    // RAM returns the byte addressed in one cycle on the next cycle
    always @(posedge clk_in) begin
        bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end

    task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz);
        bus.req_wr[ch]             = wr;
        bus.req_addr[ch*32 +: 32]  = addr;
        bus.req_wdata[ch*32 +: 32] = wd;
        bus.req_size[ch*2 +: 2]    = sz;
        bus.req_valid[ch]          = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_size = '0; bus.flush = '0;
        repeat (2) @(negedge clk_in);
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset mem_wr got %b want 0", bus.mem_wr); end
        checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset mem_a got %h want 0", bus.mem_a); end
        checks++; if (bus.mem_dout !== 8'h0) begin errors++; $display("FAIL reset mem_dout got %h want 0", bus.mem_dout); end
        checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL reset resp_valid got %b want 000", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset resp_data got %h want 0", bus.resp_data); end
        checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset req_ready got %b want 000", bus.req_ready); end
        rst_in = 1'b1;
    endtask

    task automatic test_word_read();
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        @(negedge clk_in);
        set_req(0, 1'b0, 32'h100, 32'h0, 2'd2);
        #1;
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL word_read grant got %b want 001", bus.req_ready); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_in); bus.req_valid[0] = 1'b0; #1;
            checks++;
            if (bus.mem_a !== 32'h100 + j || bus.mem_wr !== 1'b0) begin
                errors++; $display("FAIL word_read issue%0d got a=%h wr=%b want a=%h wr=0", j, bus.mem_a, bus.mem_wr, 32'h100 + j);
            end
        end
        @(negedge clk_in); #1;
        checks++; if (bus.mem_a !== 32'h0 || bus.resp_valid !== 3'b000) begin errors++; $display("FAIL word_read drain got a=%h rv=%b want a=0 rv=000", bus.mem_a, bus.resp_valid); end
        @(negedge clk_in); #1;
        checks++; if (bus.resp_valid !== 3'b001) begin errors++; $display("FAIL word_read resp_valid got %b want 001", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h44332211) begin errors++; $display("FAIL word_read resp_data got %h want 44332211", bus.resp_data); end
        @(negedge clk_in); #1;
        checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL word_read resp_after got %b want 000", bus.resp_valid); end
    endtask

    task automatic test_half_write();
        @(negedge clk_in);
        set_req(1, 1'b1, 32'h2000, 32'h0000BEEF, 2'd1);
        #1;
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL half_write grant got %b want 010", bus.req_ready); end
        @(negedge clk_in); bus.req_valid[1] = 1'b0; #1;
        checks++; if (bus.mem_a !== 32'h2000 || bus.mem_dout !== 8'hEF || bus.mem_wr !== 1'b1) begin errors++; $display("FAIL half_write byte0 got a=%h d=%h wr=%b want 2000 ef 1", bus.mem_a, bus.mem_dout, bus.mem_wr); end
        @(negedge clk_in); #1;
        checks++; if (bus.mem_a !== 32'h2001 || bus.mem_dout !== 8'hBE || bus.mem_wr !== 1'b1) begin errors++; $display("FAIL half_write byte1 got a=%h d=%h wr=%b want 2001 be 1", bus.mem_a, bus.mem_dout, bus.mem_wr); end
        @(negedge clk_in); #1;
        checks++; if (bus.resp_valid !== 3'b010 || bus.resp_data !== 32'h0) begin errors++; $display("FAIL half_write ack got rv=%b d=%h want 010 0", bus.resp_valid, bus.resp_data); end
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL half_write wr_after got %b want 0", bus.mem_wr); end
        @(negedge clk_in); #1;
        checks++; if (bus.resp_valid !== 3'b000 || bus.mem_wr !== 1'b0) begin errors++; $display("FAIL half_write idle got rv=%b wr=%b want 000 0", bus.resp_valid, bus.mem_wr); end
        checks++; if (ram[32'h2000] !== 8'hEF || ram[32'h2001] !== 8'hBE) begin errors++; $display("FAIL half_write ram got %h %h want ef be", ram[32'h2000], ram[32'h2001]); end
    endtask

    task automatic test_round_robin();
        logic [2:0] got [$];
        logic [2:0] exp_g [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        @(negedge clk_in); rst_in = 1'b0;
        @(negedge clk_in); rst_in = 1'b1;
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            @(negedge clk_in);
            if (c == 0) begin
                set_req(0, 1'b0, 32'h10, 32'h0, 2'd0);
                set_req(1, 1'b0, 32'h11, 32'h0, 2'd0);
                set_req(2, 1'b0, 32'h12, 32'h0, 2'd0);
            end
            #1;
            if (bus.req_ready !== 3'b000) got.push_back(bus.req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size()) begin errors++; $display("FAIL rr grant%0d got none want %b", i, exp_g[i]); end
            else if (got[i] !== exp_g[i]) begin errors++; $display("FAIL rr grant%0d got %b want %b", i, got[i], exp_g[i]); end
        end
        got.delete();
        @(negedge clk_in); bus.req_valid = 3'b100;
        for (int c = 0; c < 40 && got.size() < 2; c++) begin
            if (c > 0) @(negedge clk_in);
            #1;
            if (bus.req_ready !== 3'b000) got.push_back(bus.req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got.size()) begin errors++; $display("FAIL rr ch2_only%0d got none want 100", i); end
            else if (got[i] !== 3'b100) begin errors++; $display("FAIL rr ch2_only%0d got %b want 100", i, got[i]); end
        end
        @(negedge clk_in); bus.req_valid = '0;
        repeat (5) @(negedge clk_in);
    endtask

    task automatic test_flush_read();
        @(negedge clk_in);
        set_req(0, 1'b0, 32'h100, 32'h0, 2'd2);
        set_req(1, 1'b0, 32'h101, 32'h0, 2'd0);
        #1;
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL flush grant0 got %b want 001", bus.req_ready); end
        @(negedge clk_in); bus.req_valid[0] = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in); bus.flush = 3'b001; #1;
        checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL flush rv_g3 got %b want 000", bus.resp_valid); end
        @(negedge clk_in); bus.flush = 3'b000; #1;
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL flush grant1 got %b want 010", bus.req_ready); end
        checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL flush rv_g4 got %b want 000", bus.resp_valid); end
        @(negedge clk_in); bus.req_valid[1] = 1'b0; #1;
        checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL flush rv_g5 got %b want 000", bus.resp_valid); end
        @(negedge clk_in); #1;
        checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL flush rv_g6 got %b want 000", bus.resp_valid); end
        @(negedge clk_in); #1;
        checks++; if (bus.resp_valid !== 3'b010 || bus.resp_data !== 32'h22) begin errors++; $display("FAIL flush ch1_resp got rv=%b d=%h want 010 22", bus.resp_valid, bus.resp_data); end
    endtask

    task automatic test_pause();
        int nresp = 0;
        int wrs = 0;
        logic [31:0] rd = '0;
        ram[32'h300] = 8'hA1; ram[32'h301] = 8'hB2; ram[32'h302] = 8'hC3; ram[32'h303] = 8'hD4;
        @(negedge clk_in);
        set_req(0, 1'b0, 32'h300, 32'h0, 2'd2);
        #1;
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL pause grant got %b want 001", bus.req_ready); end
        @(negedge clk_in); bus.req_valid[0] = 1'b0; #1;
        checks++; if (bus.mem_a !== 32'h300) begin errors++; $display("FAIL pause issue0 got %h want 300", bus.mem_a); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in); rdy_in = 1'b0; #1;
            checks++; if (bus.mem_wr !== 1'b0 || bus.resp_valid !== 3'b000) begin errors++; $display("FAIL pause low%0d got wr=%b rv=%b want 0 000", k, bus.mem_wr, bus.resp_valid); end
        end
        @(negedge clk_in); rdy_in = 1'b1; #1;
        checks++; if (bus.mem_a !== 32'h300 || bus.mem_wr !== 1'b0) begin errors++; $display("FAIL pause reissue got a=%h wr=%b want 300 0", bus.mem_a, bus.mem_wr); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in); #1;
            if (bus.mem_wr !== 1'b0) wrs++;
            if (bus.resp_valid[0] === 1'b1) begin nresp++; rd = bus.resp_data; end
        end
        checks++; if (nresp != 1) begin errors++; $display("FAIL pause resp_count got %0d want 1", nresp); end
        checks++; if (rd !== 32'hD4C3B2A1) begin errors++; $display("FAIL pause resp_data got %h want d4c3b2a1", rd); end
        checks++; if (wrs != 0) begin errors++; $display("FAIL pause mem_wr got %0d write cycles want 0", wrs); end
    endtask

    task automatic test_async_reset();
        @(negedge clk_in);
        set_req(1, 1'b1, 32'h400, 32'h12345678, 2'd2);
        #1;
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL areset grant got %b want 010", bus.req_ready); end
        @(negedge clk_in); bus.req_valid[1] = 1'b0; #1;
        checks++; if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h400 || bus.mem_dout !== 8'h78) begin errors++; $display("FAIL areset byte0 got wr=%b a=%h d=%h want 1 400 78", bus.mem_wr, bus.mem_a, bus.mem_dout); end
        @(negedge clk_in); #1;
        checks++; if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h401) begin errors++; $display("FAIL areset byte1 got wr=%b a=%h want 1 401", bus.mem_wr, bus.mem_a); end
        #2; rst_in = 1'b0; #1;
        checks++; if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0 || bus.mem_dout !== 8'h0) begin errors++; $display("FAIL areset immediate got wr=%b a=%h d=%h want 0 0 0", bus.mem_wr, bus.mem_a, bus.mem_dout); end
        @(negedge clk_in); rst_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in); #1;
            checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL areset no_resp%0d got %b want 000", k, bus.resp_valid); end
        end
        @(negedge clk_in);
        set_req(0, 1'b0, 32'h10, 32'h0, 2'd0);
        set_req(1, 1'b0, 32'h11, 32'h0, 2'd0);
        set_req(2, 1'b0, 32'h12, 32'h0, 2'd0);
        #1;
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL areset first_grant got %b want 001", bus.req_ready); end
        @(negedge clk_in); bus.req_valid = '0;
        repeat (5) @(negedge clk_in);
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_half_write();
        test_round_robin();
        test_flush_read();
        test_pause();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
